// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory between instruction fetch and data access.
// While data keeps requesting it owns the port; fetch gets in once starve_cnt reaches STARVE_MAX.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_ren,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_data,
  output logic              inst_ack,
  input  logic              data_ren,
  input  logic              data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ack,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dout,
  input  logic [DATA_W-1:0] mem_din,
  input  logic              mem_ack,
  output logic              busy
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, INST, DATA} state_t;
  state_t state, state_nx;
  logic [CW-1:0] starve_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic wr_q, data_req, inst_elig, data_elig, starved, inst_gnt, data_gnt;
  assign data_req  = data_ren | data_wen;
  assign inst_elig = inst_ren & ~inst_ack;
  assign data_elig = data_req & ~data_ack;
  assign starved   = starve_cnt == CW'(STARVE_MAX);
  // a data request still held through its own ack cycle keeps fetch out unless fetch is starved
  assign inst_gnt  = state == IDLE && inst_elig && (starved || !data_req);
  assign data_gnt  = state == IDLE && data_elig && !inst_gnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = inst_gnt ? INST : data_gnt ? DATA : IDLE;
    else if (mem_ack) state_nx = IDLE;
  end
  always_comb begin
    mem_ren  = state == INST || (state == DATA && !wr_q);
    mem_wen  = state == DATA && wr_q;
    mem_addr = addr_q;
    mem_dout = wdata_q;
    busy     = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      inst_ack   <= 1'b0;
      data_ack   <= 1'b0;
      inst_data  <= '0;
      data_rdata <= '0;
      starve_cnt <= '0;
    end else begin
      inst_ack <= state == INST && mem_ack;
      data_ack <= state == DATA && mem_ack;
      if (inst_gnt || data_gnt) begin
        addr_q  <= inst_gnt ? inst_addr : data_addr;
        wdata_q <= inst_gnt ? '0 : data_wdata;
        wr_q    <= data_gnt && data_wen;
      end
      if (state == INST && mem_ack) inst_data <= mem_din;
      if (state == DATA && mem_ack && !wr_q) data_rdata <= mem_din;
      if (state == IDLE)
        starve_cnt <= (inst_gnt || !inst_ren) ? '0 :
                      (data_gnt && !starved) ? starve_cnt + CW'(1) : starve_cnt;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a scoreboard of expected memory accesses and acks.
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic inst_ren = 1'b0, data_ren = 1'b0, data_wen = 1'b0;
  logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
  logic [31:0] inst_data, data_rdata, mem_addr, mem_dout, mem_din;
  logic inst_ack, data_ack, mem_ren, mem_wen, mem_ack, busy;
  logic resp_ack = 1'b0, stray_ack = 1'b0;
  logic [31:0] resp_din = '0;
  logic [132:0] all_out;
  typedef struct {logic wr; logic [31:0] addr; logic [31:0] wd; int cyc;} acc_t;
  acc_t exp_acc[$];
  logic [31:0] exp_i[$], exp_d[$];
  int checks = 0, errors = 0, mem_lat = 1, n_iack = 0, n_dack = 0;

  assign mem_ack = resp_ack | stray_ack;
  assign mem_din = resp_din;
  assign all_out = {inst_data, data_rdata, mem_addr, mem_dout, inst_ack, data_ack, mem_ren, mem_wen, busy};

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(2)) dut (
    .clk(clk), .rst(rst),
    .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data), .inst_ack(inst_ack),
    .data_ren(data_ren), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_ack(data_ack),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ack(mem_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a == 32'h100 ? 32'h2402000A : {a[15:0], ~a[15:0]};
  endfunction

  // memory model: ack on the mem_lat-th strobe cycle
  initial begin
    int scnt = 0;
    forever begin
      @(negedge clk);
      if (rst && (mem_ren || mem_wen)) begin
        scnt++;
        resp_ack = scnt == mem_lat;
        if (resp_ack) resp_din = mem_val(mem_addr);
      end else begin
        scnt = 0;
        resp_ack = 1'b0;
      end
    end
  end

  // monitor: pops expected accesses and acks as the DUT presents them
  initial begin
    acc_t cur;
    bit in_acc = 0, held = 1;
    int cyc = 0;
    logic [31:0] a0, d0;
    cur = '{1'b0, 32'h0, 32'h0, 0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_acc = 0;
        continue;
      end
      if (mem_ren && mem_wen) check("strobe_exclusive", 1, 0);
      if ((mem_ren || mem_wen) && !in_acc) begin
        in_acc = 1; cyc = 1; held = 1; a0 = mem_addr; d0 = mem_dout;
        if (exp_acc.size() == 0) begin
          check("unexpected_access", mem_addr, 0);
          cur.cyc = 0;
        end else begin
          cur = exp_acc.pop_front();
          check("acc_addr", mem_addr, cur.addr);
          check("acc_wen", mem_wen, cur.wr);
          check("acc_ren", mem_ren, !cur.wr);
          if (cur.wr) check("acc_dout", mem_dout, cur.wd);
        end
      end else if (mem_ren || mem_wen) begin
        cyc++;
        if (mem_addr !== a0 || mem_dout !== d0) held = 0;
      end else if (in_acc) begin
        in_acc = 0;
        if (cur.cyc > 0) begin
          check("acc_strobe_cycles", cyc, cur.cyc);
          check("acc_operands_held", held, 1);
        end
      end
      if (inst_ack) begin
        n_iack++;
        if (exp_i.size() == 0) check("unexpected_inst_ack", 1, 0);
        else check("inst_data", inst_data, exp_i.pop_front());
      end
      if (data_ack) begin
        n_dack++;
        if (exp_d.size() == 0) check("unexpected_data_ack", 1, 0);
        else check("data_rdata", data_rdata, exp_d.pop_front());
      end
    end
  end

  // requesters hold their request through the ack cycle, then move to the next address
  task automatic run_inst(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      inst_addr = base + 32'(4 * i);
      inst_ren = 1'b1;
      for (int k = 0; k < 60 && !inst_ack; k++) @(negedge clk);
      if (!inst_ack) check("inst_ack_timeout", 0, 1);
      @(posedge clk); #1;
    end
    inst_ren = 1'b0;
  endtask

  task automatic run_data(input int n, input logic [31:0] base, input logic wr, input logic rd,
                          input logic [31:0] wd);
    for (int i = 0; i < n; i++) begin
      data_addr = base + 32'(4 * i);
      data_ren = rd; data_wen = wr; data_wdata = wd;
      for (int k = 0; k < 60 && !data_ack; k++) @(negedge clk);
      if (!data_ack) check("data_ack_timeout", 0, 1);
      @(posedge clk); #1;
    end
    data_ren = 1'b0; data_wen = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state and stray ack in IDLE
    repeat (2) @(negedge clk);
    check("reset_outputs_zero", |all_out, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk) stray_ack = 1'b1;
    @(negedge clk) stray_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_busy", busy, 0);
    check("stray_no_ack", n_iack + n_dack, 0);
    // 2: fetch with two wait states
    @(posedge clk); #1;
    mem_lat = 3;
    exp_acc.push_back('{1'b0, 32'h100, 32'h0, 3});
    exp_i.push_back(32'h2402000A);
    run_inst(1, 32'h100);
    check("t2_iack_count", n_iack, 1);
    check("t2_inst_data_held", inst_data, 32'h2402000A);
    // 3: simultaneous requests, data first
    mem_lat = 1;
    exp_acc.push_back('{1'b0, 32'h200, 32'h0, 1});
    exp_acc.push_back('{1'b0, 32'h104, 32'h0, 1});
    exp_d.push_back(32'h0200FDFF);
    exp_i.push_back(32'h0104FEFB);
    fork
      run_inst(1, 32'h104);
      run_data(1, 32'h200, 1'b0, 1'b1, 32'h0);
    join
    check("t3_iack_count", n_iack, 2);
    check("t3_dack_count", n_dack, 1);
    // 4: starvation bound of 2 gives D,D,I,D,D,I
    exp_acc.push_back('{1'b0, 32'h500, 32'h0, 1});
    exp_acc.push_back('{1'b0, 32'h504, 32'h0, 1});
    exp_acc.push_back('{1'b0, 32'h600, 32'h0, 1});
    exp_acc.push_back('{1'b0, 32'h508, 32'h0, 1});
    exp_acc.push_back('{1'b0, 32'h50C, 32'h0, 1});
    exp_acc.push_back('{1'b0, 32'h604, 32'h0, 1});
    exp_d.push_back(32'h0500FAFF);
    exp_d.push_back(32'h0504FAFB);
    exp_d.push_back(32'h0508FAF7);
    exp_d.push_back(32'h050CFAF3);
    exp_i.push_back(32'h0600F9FF);
    exp_i.push_back(32'h0604F9FB);
    fork
      run_data(4, 32'h500, 1'b0, 1'b1, 32'h0);
      run_inst(2, 32'h600);
    join
    check("t4_iack_count", n_iack, 4);
    check("t4_dack_count", n_dack, 5);
    // 5: writes leave data_rdata alone, ren+wen counts as a write
    exp_acc.push_back('{1'b1, 32'h300, 32'hDEADBEEF, 1});
    exp_d.push_back(32'h050CFAF3);
    run_data(1, 32'h300, 1'b1, 1'b0, 32'hDEADBEEF);
    exp_acc.push_back('{1'b1, 32'h304, 32'h12345678, 1});
    exp_d.push_back(32'h050CFAF3);
    run_data(1, 32'h304, 1'b1, 1'b1, 32'h12345678);
    check("t5_rdata_held", data_rdata, 32'h050CFAF3);
    check("t5_dack_count", n_dack, 7);
    // 6: reset mid-access
    mem_lat = 5;
    exp_acc.push_back('{1'b0, 32'h400, 32'h0, 0});
    data_addr = 32'h400; data_ren = 1'b1;
    for (int k = 0; k < 20 && !mem_ren; k++) @(negedge clk);
    check("t6_strobe_seen", mem_ren, 1);
    @(negedge clk); #2 rst = 1'b0;
    #1;
    check("t6_reset_outputs_zero", |all_out, 0);
    check("t6_mem_ren_drop", mem_ren, 0);
    data_ren = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk) stray_ack = 1'b1;
    @(negedge clk) stray_ack = 1'b0;
    repeat (8) @(negedge clk);
    check("t6_no_data_ack", n_dack, 7);
    check("t6_busy", busy, 0);
    check("exp_acc_empty", exp_acc.size(), 0);
    check("exp_inst_empty", exp_i.size(), 0);
    check("exp_data_empty", exp_d.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
